// File: rtl/freq_state_pkg.sv
// Shared types and helpers for the frequency-to-state selector.
// Holds the FSM state enum, a clog2 helper and the FW/NCORNER defaults.
package freq_state_pkg;

    localparam int FW_DEFAULT      = 14;
    localparam int NCORNER_DEFAULT = 80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        COMMIT = 2'd2
    } fsm_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/freq_state_sel_if.sv
// Lookup and corner-table bus of the frequency-to-state selector.
// master: drives f/f_valid/cfg_*; slave: returns f_ready, cfg_err, state, state_valid.
interface freq_state_sel_if #(
    parameter int FW = 14,
    parameter int SW = 7
);
    logic [FW-1:0] f;
    logic          f_valid;
    logic          f_ready;
    logic          cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [FW-1:0] cfg_data;
    logic          cfg_err;
    logic [SW-1:0] state;
    logic          state_valid;

    modport master (
        output f, f_valid, cfg_we, cfg_addr, cfg_data,
        input  f_ready, cfg_err, state, state_valid
    );

    modport slave (
        input  f, f_valid, cfg_we, cfg_addr, cfg_data,
        output f_ready, cfg_err, state, state_valid
    );
endinterface

// File: rtl/freq_corner_ram.sv
// Corner-frequency register file: NCORNER x FW, one write port, one async read.
// Ports: clk, rst, we/waddr/wdata (write), raddr -> rdata (read, 0 if out of range).
module freq_corner_ram #(
    parameter int FW      = 14,
    parameter int NCORNER = 80,
    parameter int SW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [SW-1:0] waddr,
    input  logic [FW-1:0] wdata,
    input  logic [SW-1:0] raddr,
    output logic [FW-1:0] rdata
);
    localparam logic [SW-1:0] NC = SW'(NCORNER);

    logic [FW-1:0] fc [NCORNER];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCORNER; k++) fc[k] <= '0;
        end else if (we) begin
            fc[waddr] <= wdata;
        end
    end

    // The search idles with mid == NCORNER once lo == hi; keep that read in range.
    assign rdata = (raddr < NC) ? fc[raddr] : '0;

endmodule

// File: rtl/freq_state_sel.sv
// Maps a measured frequency to a band state via a fixed-latency binary search.
// Ports: clk, rst (async, active high), bus (freq_state_sel_if.slave). Option: FREQ_STATE_SEL_DWELL_EN.
module freq_state_sel
    import freq_state_pkg::*;
#(
    parameter int FW      = FW_DEFAULT,
    parameter int NCORNER = NCORNER_DEFAULT,
    parameter int SW      = 7,
    parameter int DWELL   = 3
) (
    input logic            clk,
    input logic            rst,
    freq_state_sel_if.slave bus
);
    localparam logic [SW-1:0] NC   = SW'(NCORNER);
    localparam logic [SW-1:0] LAST = SW'(SW - 1);

    if (SW != clog2(NCORNER + 1)) begin : g_bad_sw
        $error("SW must equal clog2(NCORNER+1)");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("DWELL must be at least 1");
    end

    fsm_t          fsm;
    logic [FW-1:0] f_q;
    logic [FW-1:0] rd_data;
    logic [SW-1:0] lo;
    logic [SW-1:0] hi;
    logic [SW-1:0] mid;
    logic [SW-1:0] iter;
    logic [SW-1:0] cand;
    logic [SW-1:0] state_q;
    logic          valid_q;
    logic          err_q;
    logic          ready;
    logic          accept;
    logic          wr_ok;
    logic          ge;

    assign ready  = (fsm == IDLE);
    assign accept = bus.f_valid && ready;
    assign wr_ok  = bus.cfg_we && ready && (bus.cfg_addr < NC);
    assign mid    = SW'(({1'b0, lo} + {1'b0, hi}) >> 1);
    assign ge     = (f_q >= rd_data);
    assign cand   = NC - lo;

    freq_corner_ram #(
        .FW      (FW),
        .NCORNER (NCORNER),
        .SW      (SW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (mid),
        .rdata (rd_data)
    );

`ifdef FREQ_STATE_SEL_DWELL_EN
    localparam int            DW   = clog2(DWELL + 1);
    localparam logic [DW-1:0] DMAX = DW'(DWELL);

    logic [SW-1:0] prev_q;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dnext;

    // Run length of identical candidates, including the current one.
    always_comb begin
        dnext = DW'(1);
        if (cand == prev_q) begin
            dnext = (dcnt == DMAX) ? DMAX : dcnt + DW'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            f_q     <= '0;
            lo      <= '0;
            hi      <= '0;
            iter    <= '0;
            state_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef FREQ_STATE_SEL_DWELL_EN
            prev_q  <= '0;
            dcnt    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= bus.cfg_we && !wr_ok;
            unique case (fsm)
                IDLE: begin
                    if (accept) begin
                        f_q  <= bus.f;
                        lo   <= '0;
                        hi   <= NC;
                        iter <= '0;
                        fsm  <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Converged searches keep iterating as no-ops for fixed latency.
                    if (lo != hi) begin
                        if (ge) lo <= mid + SW'(1);
                        else    hi <= mid;
                    end
                    iter <= iter + SW'(1);
                    if (iter == LAST) fsm <= COMMIT;
                end
                COMMIT: begin
                    valid_q <= 1'b1;
`ifdef FREQ_STATE_SEL_DWELL_EN
                    prev_q <= cand;
                    dcnt   <= dnext;
                    if (dnext == DMAX) state_q <= cand;
`else
                    state_q <= cand;
`endif
                    fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.f_ready     = ready;
    assign bus.state       = state_q;
    assign bus.state_valid = valid_q;
    assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_freq_state_sel.sv
// Directed self-checking bench for freq_state_sel (FW=14, NCORNER=80, fc[k]=100*(k+1)).
// Define FREQ_STATE_SEL_DWELL_EN on both files to exercise the dwell variant.
module tb_freq_state_sel;
    localparam int FW = 14;
    localparam int NC = 80;
    localparam int SW = 7;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    freq_state_sel_if #(.FW(FW), .SW(SW)) bus ();

    freq_state_sel #(
        .FW      (FW),
        .NCORNER (NC),
        .SW      (SW),
        .DWELL   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

`ifdef FREQ_STATE_SEL_DWELL_EN
    int m_prev = 0;
    int m_cnt = 0;
    int m_state = 0;
`endif

    task automatic model_reset();
`ifdef FREQ_STATE_SEL_DWELL_EN
        m_prev = 0;
        m_cnt = 0;
        m_state = 0;
`endif
    endtask

    // Expected state output for a given candidate (dwell hysteresis when enabled).
    task automatic model(input int cand, output int e);
`ifdef FREQ_STATE_SEL_DWELL_EN
        if (cand == m_prev) m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
        else m_cnt = 1;
        m_prev = cand;
        if (m_cnt >= 3) m_state = cand;
        e = m_state;
`else
        e = cand;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int a, input int d);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = SW'(a);
        bus.cfg_data = FW'(d);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
    endtask

    task automatic load_table();
        for (int k = 0; k < NC; k++) cfg_write(k, 100 * (k + 1));
    endtask

    // Waits for state_valid; lat counts edges since the accept edge.
    task automatic wait_valid(input int done, output int lat, output int st);
        lat = -1;
        st = -1;
        for (int n = done + 1; n <= done + 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.state_valid) begin
                lat = n;
                st = int'(bus.state);
                break;
            end
        end
    endtask

    task automatic start(input int fv, output int rdy);
        @(negedge clk);
        bus.f = FW'(fv);
        bus.f_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.f_valid = 1'b0;
        bus.f = ~FW'(fv);
        rdy = int'(bus.f_ready);
    endtask

    task automatic run_lookup(input string tag, input int fv, input int cand);
        int rdy, lat, st, e;
        start(fv, rdy);
        check({tag, "_busy"}, rdy, 0);
        wait_valid(0, lat, st);
        check({tag, "_lat"}, lat, 8);
        model(cand, e);
        check({tag, "_state"}, st, e);
    endtask

    initial begin
        int rdy, lat, st, e, seen;
        int dw_f[5] = '{250, 250, 150, 150, 150};
`ifdef FREQ_STATE_SEL_DWELL_EN
        int dw_s[5] = '{0, 0, 0, 0, 79};
`else
        int dw_s[5] = '{78, 78, 79, 79, 79};
`endif
        rst = 1'b1;
        bus.f = '0;
        bus.f_valid = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_valid", int'(bus.state_valid), 0);
        check("rst_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 check("rst_ready", int'(bus.f_ready), 1);

        load_table();
        run_lookup("f50", 50, 80);
        run_lookup("f100", 100, 79);
        run_lookup("f8000", 8000, 0);
        run_lookup("f16383", 16383, 0);

        start(550, rdy);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = SW'(5);
        bus.cfg_data = FW'(7);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        check("busy_err", int'(bus.cfg_err), 1);
        @(posedge clk);
        #1 check("busy_err_pulse", int'(bus.cfg_err), 0);
        wait_valid(2, lat, st);
        check("busy_lat", lat, 8);
        model(75, e);
        check("busy_state", st, e);
        run_lookup("fc5_kept", 550, 75);

        cfg_write(80, 1);
        check("addr80_err", int'(bus.cfg_err), 1);
        run_lookup("addr80_noeff", 8000, 0);

        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = '0;
        bus.cfg_data = FW'(40);
        bus.f = FW'(50);
        bus.f_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        bus.f_valid = 1'b0;
        check("same_err", int'(bus.cfg_err), 0);
        wait_valid(0, lat, st);
        check("same_lat", lat, 8);
        model(79, e);
        check("same_state", st, e);
        cfg_write(0, 100);

        run_lookup("pre_rst", 550, 75);
        start(8000, rdy);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1 if (bus.state_valid) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("midrst_ready", int'(bus.f_ready), 1);
        check("midrst_state", int'(bus.state), 0);
        repeat (12) begin
            @(posedge clk);
            #1 if (bus.state_valid) seen++;
        end
        check("midrst_novalid", seen, 0);
        run_lookup("zero_table", 5, 0);

        do_reset();
        load_table();
        for (int i = 0; i < 5; i++) begin
            start(dw_f[i], rdy);
            wait_valid(0, lat, st);
            check($sformatf("dwell%0d_lat", i), lat, 8);
            check($sformatf("dwell%0d_state", i), st, dw_s[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_state_sel.md
FREQ_STATE_SEL -- requirements
Module: freq_state_sel

Interface
REQ-001 Parameter FW, default 14, frequency word width.
REQ-002 Parameter NCORNER, default 80, number of corner frequencies; NCORNER+1 output states.
REQ-003 Parameter SW, default 7, state/address width; SW SHALL equal ceil(log2(NCORNER+1)).
REQ-004 Parameter DWELL, default 3, consecutive identical results required before a state change (used only with REQ-029).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 f  in  FW  unsigned measured frequency.
REQ-008 f_valid  in  1  f is presented; a lookup is accepted when f_valid and f_ready are both high.
REQ-009 f_ready  out  1  high when idle and a lookup can be accepted.
REQ-010 cfg_we  in  1  corner-table write strobe.
REQ-011 cfg_addr  in  SW  corner index, 0..NCORNER-1.
REQ-012 cfg_data  in  FW  corner value.
REQ-013 cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-014 state  out  SW  selected state; NCORNER = lowest band, 0 = baseload/highest band.
REQ-015 state_valid  out  1  one-cycle pulse when a lookup completes.

Function
REQ-016 Result definition: count = number of corners fc[k] with f >= fc[k]; candidate = NCORNER - count.
REQ-017 Search SHALL be binary: lo=0, hi=NCORNER; each iteration mid=(lo+hi)>>1; if f>=fc[mid] lo=mid+1, else hi=mid; count=lo.
REQ-018 Exactly SW iterations per lookup, one per cycle; once lo==hi, remaining iterations are no-ops, so latency is constant.
REQ-019 FSM states: IDLE, SEARCH, COMMIT. IDLE->SEARCH on accept; SEARCH->COMMIT after SW iterations; COMMIT->IDLE unconditionally.
REQ-020 f is captured on the accept edge; later changes to f do not affect the running lookup.
REQ-021 state and state_valid update in COMMIT; state_valid rises exactly SW+1 cycles after the accept edge.
REQ-022 f_ready is high only in IDLE; back-to-back lookups are spaced SW+2 cycles apart.
REQ-023 cfg_we with f_ready high and cfg_addr < NCORNER writes fc[cfg_addr] on that edge.
REQ-024 cfg_we while busy, or with cfg_addr >= NCORNER: write dropped, cfg_err pulses the next cycle.
REQ-025 cfg_we and f_valid in the same IDLE cycle: the write completes first and the lookup uses the new value.
REQ-026 Non-ascending table: result is whatever REQ-017 yields (deterministic); no error is flagged.
REQ-027 f = all-ones with all corners = all-ones gives count = NCORNER, state 0.

Reset
REQ-028 rst asserted, including mid-search: FSM->IDLE, state=0, state_valid=0, cfg_err=0, f_ready=1 after release, all fc[k]=0, dwell counter=0; an in-flight lookup is discarded with no state_valid.

Configuration
REQ-029 With FREQ_STATE_SEL_DWELL_EN defined: on COMMIT, state updates only once the candidate has matched the previous candidate for DWELL consecutive lookups (counter saturates); state_valid still pulses every lookup, carrying the held state.
REQ-030 Without FREQ_STATE_SEL_DWELL_EN: state takes the candidate on every COMMIT; DWELL is unused and no dwell logic is built.

Structure
REQ-031 Package freq_state_pkg holds the FSM state enum, a clog2 function and the FW/NCORNER defaults.
REQ-032 Sub-module freq_corner_ram: NCORNER x FW register file with one write port and one combinational read port (mid index), reset to zero.

Verification (FW=14, NCORNER=80, fc[k]=100*(k+1))
REQ-033 f=50 -> state 80; f=100 -> state 79; f=8000 -> state 0; f=16383 -> state 0; each state_valid exactly 8 cycles after accept.
REQ-034 Write while busy to fc[5] -> cfg_err pulse, fc[5] unchanged; cfg_addr=80 in IDLE -> cfg_err.
REQ-035 rst asserted at search cycle 3 -> no state_valid; state=0; f_ready=1 on the first edge after release.
REQ-036 Same-cycle cfg_we fc[0]=40 with f_valid, f=50 -> state 79.
REQ-037 DWELL_EN, DWELL=3: lookups with f=250,250,150,150,150 -> state holds 0 (reset value), 0, 0, 0, then becomes 79 on the fifth lookup; without the macro -> 78,78,79,79,79.
